entrada_io_responder: RTL and testbench

Input-side responder for the CPU's `in` instruction. When the CPU requests input, the block collects decimal digits from the 4-bit board switches, one per debounced button press, and accumulates them into a binary value. It returns that value with a one-cycle acknowledge. It sits between the DeBounce output and the CPU register-write mux (`dadosEntrada` path), and it complements the display/output path.

---
 rtl/entrada_io_responder.sv | 163 ++++++++++++++++
 tb/tb_entrada_io_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/entrada_io_responder.sv
// entrada_io_responder: collects decimal digits from the board switches, one per
// debounced button press, for the CPU "in" instruction. It returns the accumulated
// binary value with a one-cycle acknowledge.
// Optional feature macro: ENTRADA_ECO_EN adds a three-digit echo of the typed digits
// (eco_unidade / eco_dezena / eco_centena) for the seven-segment display.
module entrada_io_responder #(
    parameter int unsigned MAX_DIGITS = 3,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              botao,
    input  logic [3:0]        chaves,
    output logic [DATA_W-1:0] dado,
    output logic              ack,
    output logic              aguardando,
    output logic [3:0]        num_digitos
`ifdef ENTRADA_ECO_EN
    ,
    output logic [3:0]        eco_unidade,
    output logic [3:0]        eco_dezena,
    output logic [3:0]        eco_centena
`endif
);

    localparam logic [3:0] MAX_NUM   = 4'(MAX_DIGITS);
    localparam logic [3:0] LAST_DIG  = 4'd9;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COLETA = 2'd1,
        FIM    = 2'd2,
        LIBERA = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic [3:0]        num_q, num_d;
    logic              ack_q, ack_d;
    logic              agu_q, agu_d;
    logic              botao_ant_q;
    logic              press_c;
    logic [DATA_W-1:0] acc_x10_c;
`ifdef ENTRADA_ECO_EN
    logic [3:0]        eco_u_q, eco_u_d;
    logic [3:0]        eco_d_q, eco_d_d;
    logic [3:0]        eco_c_q, eco_c_d;
`endif

    // Rising edge of the debounced button; a button already held needs a release first
    assign press_c   = botao & ~botao_ant_q;
    // acc*10 as two shifts, truncated to DATA_W
    assign acc_x10_c = (acc_q << 3) + (acc_q << 1);

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        num_d   = num_q;
        dado_d  = dado_q;
        ack_d   = 1'b0;
        agu_d   = agu_q;
`ifdef ENTRADA_ECO_EN
        eco_u_d = eco_u_q;
        eco_d_d = eco_d_q;
        eco_c_d = eco_c_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = COLETA;
                    acc_d   = '0;
                    num_d   = 4'd0;
                    agu_d   = 1'b1;
`ifdef ENTRADA_ECO_EN
                    eco_u_d = 4'd0;
                    eco_d_d = 4'd0;
                    eco_c_d = 4'd0;
`endif
                end
            end
            COLETA: begin
                if (!req) begin
                    // Abort beats any press in the same cycle
                    state_d = IDLE;
                    agu_d   = 1'b0;
                end else if (press_c) begin
                    if (chaves <= LAST_DIG) begin
                        acc_d = acc_x10_c + DATA_W'(chaves);
                        num_d = num_q + 4'd1;
`ifdef ENTRADA_ECO_EN
                        eco_c_d = eco_d_q;
                        eco_d_d = eco_u_q;
                        eco_u_d = chaves;
`endif
                        if (num_d == MAX_NUM) begin
                            state_d = FIM;
                        end
                    end else if (chaves == KEY_ENTER) begin
                        state_d = FIM;
                    end
                end
            end
            FIM: begin
                dado_d  = acc_q;
                ack_d   = 1'b1;
                agu_d   = 1'b0;
                state_d = LIBERA;
            end
            LIBERA: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            num_q       <= 4'd0;
            dado_q      <= '0;
            ack_q       <= 1'b0;
            agu_q       <= 1'b0;
            botao_ant_q <= 1'b0;
`ifdef ENTRADA_ECO_EN
            eco_u_q     <= 4'd0;
            eco_d_q     <= 4'd0;
            eco_c_q     <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            num_q       <= num_d;
            dado_q      <= dado_d;
            ack_q       <= ack_d;
            agu_q       <= agu_d;
            botao_ant_q <= botao;
`ifdef ENTRADA_ECO_EN
            eco_u_q     <= eco_u_d;
            eco_d_q     <= eco_d_d;
            eco_c_q     <= eco_c_d;
`endif
        end
    end

    assign dado        = dado_q;
    assign ack         = ack_q;
    assign aguardando  = agu_q;
    assign num_digitos = num_q;
`ifdef ENTRADA_ECO_EN
    assign eco_unidade = eco_u_q;
    assign eco_dezena  = eco_d_q;
    assign eco_centena = eco_c_q;
`endif

endmodule

// File: tb/tb_entrada_io_responder.sv
// Directed bench for entrada_io_responder: digit entry, early enter, ignored keys,
// held button, abort, asynchronous reset and (with ENTRADA_ECO_EN) the digit echo.
module tb_entrada_io_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        botao;
    logic [3:0]  chaves;
    logic [31:0] dado;
    logic        ack;
    logic        aguardando;
    logic [3:0]  num_digitos;
`ifdef ENTRADA_ECO_EN
    logic [3:0]  eco_unidade, eco_dezena, eco_centena;
`endif

    int checks = 0;
    int errors = 0;

    entrada_io_responder #(.MAX_DIGITS(3), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .botao       (botao),
        .chaves      (chaves),
        .dado        (dado),
        .ack         (ack),
        .aguardando  (aguardando),
        .num_digitos (num_digitos)
`ifdef ENTRADA_ECO_EN
        ,
        .eco_unidade (eco_unidade),
        .eco_dezena  (eco_dezena),
        .eco_centena (eco_centena)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One press: key sampled high at the first edge, released at the second
    task automatic press(input logic [3:0] key);
        chaves = key;
        botao  = 1'b1;
        step();
        botao  = 1'b0;
        step();
    endtask

    // Drop req after an ack and return to IDLE
    task automatic release_req();
        step();
        req = 1'b0;
        step();
    endtask

    initial begin
        reset  = 1'b1;
        req    = 1'b0;
        botao  = 1'b0;
        chaves = 4'd0;
        step();
        step();
        check("rst_dado", dado, 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_agu", 32'(aguardando), 32'd0);
        check("rst_num", 32'(num_digitos), 32'd0);
        reset = 1'b0;
        step();

        // Basic entry: 1,2,3 terminates automatically at MAX_DIGITS
        req = 1'b1;
        step();
        check("basic_agu_on", 32'(aguardando), 32'd1);
        press(4'd1);
        press(4'd2);
        check("basic_num2", 32'(num_digitos), 32'd2);
        check("basic_noack", 32'(ack), 32'd0);
        press(4'd3);
        check("basic_ack", 32'(ack), 32'd1);
        check("basic_dado", dado, 32'd123);
        check("basic_num3", 32'(num_digitos), 32'd3);
        check("basic_agu_off", 32'(aguardando), 32'd0);
        step();
        check("basic_ack_low", 32'(ack), 32'd0);
        check("basic_dado_hold", dado, 32'd123);
        req = 1'b0;
        step();

        // Early enter after a single digit
        req = 1'b1;
        step();
        check("early_num_clr", 32'(num_digitos), 32'd0);
        press(4'd7);
        press(4'hF);
        check("early_ack", 32'(ack), 32'd1);
        check("early_dado", dado, 32'd7);
        check("early_num", 32'(num_digitos), 32'd1);
        release_req();

        // Enter with no digits returns zero
        req = 1'b1;
        step();
        press(4'hF);
        check("zero_ack", 32'(ack), 32'd1);
        check("zero_dado", dado, 32'd0);
        check("zero_num", 32'(num_digitos), 32'd0);
        release_req();

        // Keys 10..14 are ignored
        req = 1'b1;
        step();
        press(4'd4);
        press(4'hA);
        press(4'hC);
        check("rej_num1", 32'(num_digitos), 32'd1);
        press(4'd5);
        check("rej_noack", 32'(ack), 32'd0);
        press(4'hF);
        check("rej_ack", 32'(ack), 32'd1);
        check("rej_dado", dado, 32'd45);
        check("rej_num", 32'(num_digitos), 32'd2);
        release_req();

        // Button held before req: needs a release and a new press
        chaves = 4'd6;
        botao  = 1'b1;
        step();
        req = 1'b1;
        step();
        step();
        step();
        step();
        step();
        check("held_num0", 32'(num_digitos), 32'd0);
        check("held_agu", 32'(aguardando), 32'd1);
        botao = 1'b0;
        step();
        botao = 1'b1;
        step();
        check("held_num1", 32'(num_digitos), 32'd1);
        botao = 1'b0;
        step();
        press(4'hF);
        check("held_ack", 32'(ack), 32'd1);
        check("held_dado", dado, 32'd6);
        release_req();

        // Abort after digit 9: no ack, dado retained
        req = 1'b1;
        step();
        press(4'd9);
        check("abort_num1", 32'(num_digitos), 32'd1);
        req = 1'b0;
        step();
        check("abort_agu", 32'(aguardando), 32'd0);
        check("abort_noack", 32'(ack), 32'd0);
        step();
        check("abort_noack2", 32'(ack), 32'd0);
        check("abort_dado", dado, 32'd6);

        // req falls in the same cycle as an enter press: abort wins
        req = 1'b1;
        step();
        press(4'd2);
        req    = 1'b0;
        chaves = 4'hF;
        botao  = 1'b1;
        step();
        botao = 1'b0;
        step();
        check("simul_noack", 32'(ack), 32'd0);
        check("simul_agu", 32'(aguardando), 32'd0);
        step();
        check("simul_noack2", 32'(ack), 32'd0);
        check("simul_dado", dado, 32'd6);

        // Asynchronous reset in the middle of collection
        req = 1'b1;
        step();
        press(4'd5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_dado", dado, 32'd0);
        check("arst_num", 32'(num_digitos), 32'd0);
        check("arst_agu", 32'(aguardando), 32'd0);
        check("arst_ack", 32'(ack), 32'd0);
        req = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("arst_idle_agu", 32'(aguardando), 32'd0);
        req = 1'b1;
        step();
        check("arst_restart_agu", 32'(aguardando), 32'd1);
        press(4'd8);
        press(4'hF);
        check("arst_after_dado", dado, 32'd8);
        release_req();

`ifdef ENTRADA_ECO_EN
        // Echo of digits 3, 0, 8
        req = 1'b1;
        step();
        check("eco_clr_u", 32'(eco_unidade), 32'd0);
        press(4'd3);
        press(4'd0);
        press(4'd8);
        check("eco_ack", 32'(ack), 32'd1);
        check("eco_dado", dado, 32'd308);
        check("eco_centena", 32'(eco_centena), 32'd3);
        check("eco_dezena", 32'(eco_dezena), 32'd0);
        check("eco_unidade", 32'(eco_unidade), 32'd8);
        release_req();
        check("eco_hold_u", 32'(eco_unidade), 32'd8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
